// File: rtl/uart_rx_monitor_if.sv
// Show-ahead byte stream from the UART receive monitor to its consumer.
// The producer drives valid/payload; the consumer drives ready.
interface uart_rx_monitor_if #(
   parameter int DATA_BITS = 8
);
   logic                 io_data_valid;
   logic                 io_data_ready;
   logic [DATA_BITS-1:0] io_data_payload;

   modport master (
      output io_data_valid,
      output io_data_payload,
      input  io_data_ready
   );

   modport slave (
      input  io_data_valid,
      input  io_data_payload,
      output io_data_ready
   );
endinterface

// File: rtl/uart_rx_monitor.sv
// UART 8N1 receiver feeding a show-ahead byte FIFO, with CTS driven
// from FIFO occupancy. Bench-side monitor for the SoC uartStd TX line.
module uart_rx_monitor #(
   parameter int CLOCK_HZ   = 100000000,
   parameter int BAUD       = 115200,
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                            io_clock,
   input  logic                            io_reset,
   input  logic                            io_rxd,
   output logic                            io_cts,
   uart_rx_monitor_if.master               data,
   output logic                            io_frameError,
   output logic                            io_overflow,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] io_fifoLevel
);
   localparam int CPB = CLOCK_HZ / BAUD;
   localparam int CW  = $clog2(CPB + 1);
   localparam int BW  = $clog2(DATA_BITS + 1);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int LW  = $clog2(FIFO_DEPTH + 1);

   localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CPB - 1);
   localparam logic [BW-1:0] LAST_B  = BW'(DATA_BITS - 1);
   localparam logic [LW-1:0] FULL_L  = LW'(FIFO_DEPTH);
   localparam logic [LW-1:0] CTS_L   = LW'(FIFO_DEPTH - 2);

   typedef enum logic [2:0] {
      S_BREAK,
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   logic       sync1, sync2, prev;
   logic [1:0] settle;
   logic       primed, fall;

   state_t               state, state_n;
   logic [CW-1:0]        cnt, cnt_n;
   logic [BW-1:0]        bits, bits_n;
   logic [DATA_BITS-1:0] shift, shift_n;
   logic                 push, ferr;

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr, rd;
   logic [LW-1:0]        level, level_n;
   logic                 valid, pop, full, wr_en, drop;

   // sync flops hold their reset value for two cycles after reset,
   // so BREAK must not trust them until the real pin has shifted in
   always_ff @(posedge io_clock) begin
      if (io_reset) begin
         sync1  <= 1'b1;
         sync2  <= 1'b1;
         prev   <= 1'b1;
         settle <= 2'd0;
      end else begin
         sync1 <= io_rxd;
         sync2 <= sync1;
         prev  <= sync2;
         if (!settle[1]) settle <= settle + 2'd1;
      end
   end

   assign primed = settle[1];
   assign fall   = prev & ~sync2;

   always_ff @(posedge io_clock) begin
      if (io_reset) begin
         state <= S_BREAK;
         cnt   <= '0;
         bits  <= '0;
         shift <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         bits  <= bits_n;
         shift <= shift_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt + 1'b1;
      bits_n  = bits;
      shift_n = shift;
      push    = 1'b0;
      ferr    = 1'b0;
      unique case (state)
         S_BREAK: begin
            cnt_n = '0;
            if (primed && sync2) state_n = S_IDLE;
         end
         S_IDLE: begin
            cnt_n = '0;
            if (fall) state_n = S_START;
         end
         S_START: begin
            if (cnt == HALF_M1) begin
               cnt_n   = '0;
               bits_n  = '0;
               state_n = sync2 ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (cnt == FULL_M1) begin
               cnt_n   = '0;
               shift_n = {sync2, shift[DATA_BITS-1:1]};
               bits_n  = bits + 1'b1;
               if (bits == LAST_B) state_n = S_STOP;
            end
         end
         S_STOP: begin
            if (cnt == FULL_M1) begin
               cnt_n = '0;
               if (sync2) begin
                  push    = 1'b1;
                  state_n = S_IDLE;
               end else begin
                  ferr    = 1'b1;
                  state_n = S_BREAK;
               end
            end
         end
         default: state_n = S_BREAK;
      endcase
   end

   assign valid = (level != '0);
   assign full  = (level == FULL_L);
   assign pop   = valid & data.io_data_ready;
   assign wr_en = push & (~full | pop);
   assign drop  = push & full & ~pop;

   always_comb begin
      level_n = level;
      if (wr_en && !pop) level_n = level + 1'b1;
      else if (!wr_en && pop) level_n = level - 1'b1;
   end

   always_ff @(posedge io_clock) begin
      if (wr_en) mem[wr] <= shift;
   end

   always_ff @(posedge io_clock) begin
      if (io_reset) begin
         wr            <= '0;
         rd            <= '0;
         level         <= '0;
         io_overflow   <= 1'b0;
         io_cts        <= 1'b1;
         io_frameError <= 1'b0;
      end else begin
         if (wr_en) wr <= wr + 1'b1;
         if (pop) rd <= rd + 1'b1;
         level         <= level_n;
         if (drop) io_overflow <= 1'b1;
         io_cts        <= (level_n <= CTS_L);
         io_frameError <= ferr;
      end
   end

   assign io_fifoLevel         = level;
   assign data.io_data_valid   = valid;
   assign data.io_data_payload = valid ? mem[rd] : '0;
endmodule

// File: tb/tb_uart_rx_monitor.sv
// Self-checking bench for uart_rx_monitor at a reduced bit time.
// Expected values come from frame timing arithmetic and byte queues.
module tb_uart_rx_monitor;
   localparam int CLK_HZ = 1600;
   localparam int BAUD   = 100;
   localparam int CPB    = CLK_HZ / BAUD;
   localparam int HALF   = CPB / 2;
   localparam int DEPTH  = 16;
   // sync(2) + half bit(HALF-1) + 1 + 8 data bits + stop bit + 1 to valid
   localparam int LAT    = 2 + (HALF - 1) + 1 + 8 * CPB + CPB + 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rxd = 1'b1;
   logic       cts, ferr, ovf;
   logic [4:0] level;

   int checks = 0;
   int errors = 0;
   int ferr_cycles = 0;

   uart_rx_monitor_if #(.DATA_BITS(8)) dif ();

   uart_rx_monitor #(
      .CLOCK_HZ  (CLK_HZ),
      .BAUD      (BAUD),
      .DATA_BITS (8),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .io_clock     (clk),
      .io_reset     (rst),
      .io_rxd       (rxd),
      .io_cts       (cts),
      .data         (dif),
      .io_frameError(ferr),
      .io_overflow  (ovf),
      .io_fifoLevel (level)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (ferr === 1'b1) ferr_cycles++;

   task automatic send_bit(input logic v, input int n);
      rxd = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      send_bit(1'b0, CPB);
      for (int i = 0; i < 8; i++) send_bit(b[i], CPB);
      send_bit(stop, CPB);
   endtask

   task automatic pop(output logic [7:0] b);
      b = dif.io_data_payload;
      dif.io_data_ready = 1'b1;
      @(negedge clk);
      dif.io_data_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      dif.io_data_ready = 1'b0;
      rxd = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (cts !== 1'b1) begin
         errors++; $display("FAIL reset_cts got %b want 1", cts);
      end
      checks++;
      if (dif.io_data_valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid got %b want 0", dif.io_data_valid);
      end
      checks++;
      if (dif.io_data_payload !== 8'h00) begin
         errors++; $display("FAIL reset_payload got %h want 00", dif.io_data_payload);
      end
      checks++;
      if (ferr !== 1'b0 || ovf !== 1'b0) begin
         errors++; $display("FAIL reset_flags got ferr=%b ovf=%b want 0 0", ferr, ovf);
      end
      checks++;
      if (level !== 5'd0) begin
         errors++; $display("FAIL reset_level got %0d want 0", level);
      end
      rst = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_single();
      int t;
      int f0;
      logic [7:0] b;
      f0 = ferr_cycles;
      t = 0;
      fork
         send_frame(8'h55, 1'b1);
         begin
            while (dif.io_data_valid !== 1'b1 && t < LAT + 20) begin
               @(negedge clk);
               t++;
            end
         end
      join
      checks++;
      if (t < LAT - 2 || t > LAT + 2) begin
         errors++; $display("FAIL single_latency got %0d want %0d+-2", t, LAT);
      end
      checks++;
      if (dif.io_data_payload !== 8'h55) begin
         errors++; $display("FAIL single_payload got %h want 55", dif.io_data_payload);
      end
      pop(b);
      checks++;
      if (level !== 5'd0 || dif.io_data_valid !== 1'b0) begin
         errors++; $display("FAIL single_drain got level=%0d valid=%b want 0 0",
                            level, dif.io_data_valid);
      end
      checks++;
      if (ferr_cycles != f0) begin
         errors++; $display("FAIL single_ferr got %0d want 0", ferr_cycles - f0);
      end
   endtask

   task automatic test_glitch();
      int f0;
      logic [7:0] b;
      f0 = ferr_cycles;
      send_bit(1'b0, 4);
      send_bit(1'b1, 3 * CPB);
      checks++;
      if (dif.io_data_valid !== 1'b0 || level !== 5'd0 || ferr_cycles != f0) begin
         errors++; $display("FAIL glitch_quiet got valid=%b level=%0d ferr=%0d want 0 0 0",
                            dif.io_data_valid, level, ferr_cycles - f0);
      end
      send_frame(8'hA3, 1'b1);
      checks++;
      if (dif.io_data_valid !== 1'b1 || dif.io_data_payload !== 8'hA3) begin
         errors++; $display("FAIL glitch_next got valid=%b data=%h want 1 a3",
                            dif.io_data_valid, dif.io_data_payload);
      end
      pop(b);
   endtask

   task automatic test_frame_error();
      int f0;
      logic [7:0] v;
      logic [7:0] b;
      f0 = ferr_cycles;
      v = 8'h3C;
      send_bit(1'b0, CPB);
      for (int i = 0; i < 8; i++) send_bit(v[i], CPB);
      send_bit(1'b0, 6 * CPB);
      send_bit(1'b1, 2 * CPB);
      checks++;
      if (ferr_cycles - f0 != 1) begin
         errors++; $display("FAIL ferr_pulse got %0d cycles want 1", ferr_cycles - f0);
      end
      checks++;
      if (level !== 5'd0 || dif.io_data_valid !== 1'b0) begin
         errors++; $display("FAIL ferr_level got level=%0d valid=%b want 0 0",
                            level, dif.io_data_valid);
      end
      send_frame(8'h81, 1'b1);
      checks++;
      if (dif.io_data_valid !== 1'b1 || dif.io_data_payload !== 8'h81) begin
         errors++; $display("FAIL ferr_next got valid=%b data=%h want 1 81",
                            dif.io_data_valid, dif.io_data_payload);
      end
      pop(b);
   endtask

   task automatic test_overflow_cts();
      int exp_lvl;
      logic [7:0] b;
      dif.io_data_ready = 1'b0;
      for (int i = 0; i <= DEPTH; i++) begin
         send_frame(8'(i), 1'b1);
         exp_lvl = (i + 1 > DEPTH) ? DEPTH : i + 1;
         checks++;
         if (level !== 5'(exp_lvl)) begin
            errors++; $display("FAIL ovf_level[%0d] got %0d want %0d", i, level, exp_lvl);
         end
         checks++;
         if (cts !== (exp_lvl <= DEPTH - 2)) begin
            errors++; $display("FAIL ovf_cts[%0d] got %b want %b", i, cts,
                               exp_lvl <= DEPTH - 2);
         end
         checks++;
         if (ovf !== (i + 1 > DEPTH)) begin
            errors++; $display("FAIL ovf_flag[%0d] got %b want %b", i, ovf, i + 1 > DEPTH);
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         pop(b);
         checks++;
         if (b !== 8'(i)) begin
            errors++; $display("FAIL ovf_pop[%0d] got %h want %h", i, b, 8'(i));
         end
      end
      checks++;
      if (level !== 5'd0 || ovf !== 1'b1 || cts !== 1'b1) begin
         errors++; $display("FAIL ovf_after got level=%0d ovf=%b cts=%b want 0 1 1",
                            level, ovf, cts);
      end
      do_reset();
      @(negedge clk);
      checks++;
      if (ovf !== 1'b0) begin
         errors++; $display("FAIL ovf_clear got %b want 0", ovf);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [7:0] sent [3];
      logic [7:0] got [$];
      int max_lvl;
      int long_beat;
      int cts_low;
      logic last_v;
      sent[0] = 8'hFF;
      sent[1] = 8'h00;
      sent[2] = 8'h5A;
      max_lvl = 0;
      long_beat = 0;
      cts_low = 0;
      last_v = 1'b0;
      dif.io_data_ready = 1'b1;
      fork
         for (int k = 0; k < 3; k++) send_frame(sent[k], 1'b1);
         for (int c = 0; c < 30 * CPB + 20; c++) begin
            @(negedge clk);
            if (dif.io_data_valid === 1'b1) begin
               got.push_back(dif.io_data_payload);
               if (last_v) long_beat++;
            end
            last_v = (dif.io_data_valid === 1'b1);
            if (int'(level) > max_lvl) max_lvl = int'(level);
            if (cts !== 1'b1) cts_low++;
         end
      join
      dif.io_data_ready = 1'b0;
      checks++;
      if (got.size() != 3) begin
         errors++; $display("FAIL b2b_count got %0d want 3", got.size());
      end
      for (int k = 0; k < 3 && k < got.size(); k++) begin
         checks++;
         if (got[k] !== sent[k]) begin
            errors++; $display("FAIL b2b_data[%0d] got %h want %h", k, got[k], sent[k]);
         end
      end
      checks++;
      if (long_beat != 0 || max_lvl > 1 || cts_low != 0) begin
         errors++; $display("FAIL b2b_flow got long=%0d maxlvl=%0d ctslow=%0d want 0 <=1 0",
                            long_beat, max_lvl, cts_low);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] v;
      logic [7:0] b;
      v = 8'($urandom);
      send_bit(1'b0, CPB);
      for (int i = 0; i < 4; i++) send_bit(v[i], CPB);
      rxd = 1'b0;
      repeat (HALF) @(negedge clk);
      do_reset();
      send_bit(1'b0, 2 * CPB);
      send_bit(1'b1, 2 * CPB);
      checks++;
      if (dif.io_data_valid !== 1'b0 || level !== 5'd0) begin
         errors++; $display("FAIL rstmid_quiet got valid=%b level=%0d want 0 0",
                            dif.io_data_valid, level);
      end
      send_frame(8'h7E, 1'b1);
      checks++;
      if (dif.io_data_valid !== 1'b1 || dif.io_data_payload !== 8'h7E) begin
         errors++; $display("FAIL rstmid_next got valid=%b data=%h want 1 7e",
                            dif.io_data_valid, dif.io_data_payload);
      end
      pop(b);
   endtask

   task automatic test_random();
      localparam int N = 24;
      logic [7:0] sent [$];
      logic [7:0] got [$];
      logic [7:0] hold_data;
      logic hold;
      logic r;
      int cyc;
      int f0;
      f0 = ferr_cycles;
      hold = 1'b0;
      hold_data = '0;
      cyc = 0;
      for (int k = 0; k < N; k++) sent.push_back(8'($urandom));
      fork
         for (int k = 0; k < N; k++) begin
            send_frame(sent[k], 1'b1);
            send_bit(1'b1, $urandom_range(0, CPB));
         end
         begin
            while (got.size() < N && cyc < N * (12 * CPB) + 100) begin
               @(negedge clk);
               cyc++;
               if (hold) begin
                  checks++;
                  if (dif.io_data_valid !== 1'b1 || dif.io_data_payload !== hold_data) begin
                     errors++; $display("FAIL rand_stable got valid=%b data=%h want 1 %h",
                                        dif.io_data_valid, dif.io_data_payload, hold_data);
                  end
               end
               r = 1'($urandom_range(0, 1));
               dif.io_data_ready = r;
               if (dif.io_data_valid === 1'b1 && r) got.push_back(dif.io_data_payload);
               hold = (dif.io_data_valid === 1'b1) && !r;
               hold_data = dif.io_data_payload;
            end
            @(negedge clk);
            dif.io_data_ready = 1'b0;
         end
      join
      checks++;
      if (got.size() != N) begin
         errors++; $display("FAIL rand_count got %0d want %0d", got.size(), N);
      end
      for (int k = 0; k < N && k < got.size(); k++) begin
         checks++;
         if (got[k] !== sent[k]) begin
            errors++; $display("FAIL rand_data[%0d] got %h want %h", k, got[k], sent[k]);
         end
      end
      checks++;
      if (level !== 5'd0 || ferr_cycles != f0) begin
         errors++; $display("FAIL rand_end got level=%0d ferr=%0d want 0 0",
                            level, ferr_cycles - f0);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_glitch();
      test_frame_error();
      test_overflow_cts();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
